// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types for the load/store unit.
// FSM states, byte-lane widths and the request address check.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    WR,
    RESP
  } lsu_state_e;

  localparam int LANE_W = 2;
  localparam int BYTE_W = 8;

  // Out of range when the word index does not fit the memory;
  // misaligned when a word access has nonzero lane bits.
  function automatic logic lsu_addr_err(
    input logic [31:0] addr,
    input logic        is_byte,
    input logic [31:0] words
  );
    logic range_err;
    logic align_err;
    range_err = {2'b00, addr[31:2]} >= words;
    align_err = !is_byte && (addr[LANE_W-1:0] != '0);
    return range_err || align_err;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: zero-extending byte extract and byte merge.
// word_i/lane_i/byte_i in; ext_o (lane n, zero-extended),
// merged_o (word_i with lane n replaced). Built only with
// LSU_BYTE_ACCESS_EN.
`ifdef LSU_BYTE_ACCESS_EN
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0]       word_i,
  input  logic [LANE_W-1:0] lane_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [31:0]       ext_o,
  output logic [31:0]       merged_o
);

  logic [4:0] sh;

  assign sh = {lane_i, 3'b000};

  always_comb begin
    ext_o                  = '0;
    ext_o[BYTE_W-1:0]      = word_i[sh +: BYTE_W];
    merged_o               = word_i;
    merged_o[sh +: BYTE_W] = byte_i;
  end

endmodule
`endif

// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time load/store initiator for a
// word-addressed memory with registered read data.
// Ports: clk, reset (sync, active low); req_* request with
// valid/ready; resp_* one-cycle response; mem_* memory side.
// LSU_BYTE_ACCESS_EN enables LDRB/STRB (else byte = error).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 256,
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_error,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_dataIn,
  input  logic [31:0] mem_dataOut,
  output logic        mem_enable,
  output logic        mem_readNotWrite
);

  lsu_state_e state_q, state_d;

  logic                 err_q, err_d;
  logic [ADDR_BITS-1:0] widx_q, widx_d;
  logic [31:0]          wdat_q, wdat_d;
  logic [31:0]          rdat_q, rdat_d;
  logic                 accept;
  logic                 req_err;

`ifdef LSU_BYTE_ACCESS_EN
  logic              wr_q, wr_d;
  logic              byte_q, byte_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [31:0]       lane_ext;
  logic [31:0]       lane_mrg;

  // Merge uses the store byte kept in the low lane of wdat_q.
  lsu_byte_lane u_lane (
    .word_i   (mem_dataOut),
    .lane_i   (lane_q),
    .byte_i   (wdat_q[BYTE_W-1:0]),
    .ext_o    (lane_ext),
    .merged_o (lane_mrg)
  );

  assign req_err = lsu_addr_err(req_addr, req_byte,
                                32'(MEM_WORDS));
`else
  assign req_err = req_byte
                || lsu_addr_err(req_addr, 1'b0,
                                32'(MEM_WORDS));
`endif

  assign accept = req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    widx_d  = widx_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
`ifdef LSU_BYTE_ACCESS_EN
    wr_d    = wr_q;
    byte_d  = byte_q;
    lane_d  = lane_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          err_d  = req_err;
          widx_d = req_addr[ADDR_BITS+1:2];
          wdat_d = req_write ? req_wdata : '0;
          rdat_d = '0;
`ifdef LSU_BYTE_ACCESS_EN
          wr_d   = req_write;
          byte_d = req_byte;
          lane_d = req_addr[LANE_W-1:0];
`endif
          if (req_err) begin
            state_d = RESP;
          end else if (req_write && !req_byte) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: state_d = CAP;
      CAP: begin
`ifdef LSU_BYTE_ACCESS_EN
        if (wr_q) begin
          wdat_d  = lane_mrg;
          state_d = WR;
        end else begin
          rdat_d  = byte_q ? lane_ext : mem_dataOut;
          state_d = RESP;
        end
`else
        rdat_d  = mem_dataOut;
        state_d = RESP;
`endif
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      widx_q  <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
`ifdef LSU_BYTE_ACCESS_EN
      wr_q    <= 1'b0;
      byte_q  <= 1'b0;
      lane_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      widx_q  <= widx_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
`ifdef LSU_BYTE_ACCESS_EN
      wr_q    <= wr_d;
      byte_q  <= byte_d;
      lane_q  <= lane_d;
`endif
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_error = resp_valid && err_q;
  assign resp_rdata = resp_valid ? rdat_q : '0;

  assign mem_addr   = (state_q == IDLE) ? '0
                    : 32'(widx_q);
  assign mem_dataIn = wdat_q;
  // Gate with reset so a reset landing in WR drops the write.
  assign mem_enable = (state_q == WR) && reset;
  assign mem_readNotWrite = (state_q != WR);

endmodule
